// File: rtl/bram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_pkg                                                                   |
// | Shared types and byte-lane merge helper for the dual-port BRAM controller. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package bram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } write_mode_e;

  typedef enum logic [0:0] {
    ClearIdle = 1'b0,
    ClearRun  = 1'b1
  } clear_state_e;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int c_max_dw = 1024;
  localparam int c_max_be = c_max_dw / 8;

  function automatic logic [c_max_dw-1:0] be_merge(
    input logic [c_max_dw-1:0] old_w,
    input logic [c_max_dw-1:0] new_w,
    input logic [c_max_be-1:0] be
  );
    logic [c_max_dw-1:0] res;
    res = old_w;
    for (int i = 0; i < c_max_be; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_read_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_read_pipe                                                             |
// | Delays one port's {q, rvalid, err} by ReadLatency (1 or 2) cycles.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bram_read_pipe #(
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_valid,
  input  logic                 i_err,
  input  logic                 i_hold,
  input  logic [DataWidth-1:0] i_data,
  output logic [DataWidth-1:0] o_q,
  output logic                 o_rvalid,
  output logic                 o_err
);

  logic                 w_v;
  logic                 w_e;
  logic                 w_h;
  logic [DataWidth-1:0] w_d;

  generate
    if (ReadLatency == 2) begin : g_lat2
      logic                 r_v;
      logic                 r_e;
      logic                 r_h;
      logic [DataWidth-1:0] r_d;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_v <= 1'b0;
          r_e <= 1'b0;
          r_h <= 1'b0;
          r_d <= '0;
        end else begin
          r_v <= i_valid;
          r_e <= i_valid & i_err;
          r_h <= i_valid & i_hold;
          r_d <= i_data;
        end
      end
      assign w_v = r_v;
      assign w_e = r_e;
      assign w_h = r_h;
      assign w_d = r_d;
    end else begin : g_lat1
      assign w_v = i_valid;
      assign w_e = i_err;
      assign w_h = i_hold;
      assign w_d = i_data;
    end
  endgenerate

  // q only moves on a valid, non-holding response so it keeps its last value otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      o_q      <= '0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= w_v;
      o_err    <= w_v & w_e;
      if (w_v && !w_h) o_q <= w_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_port_bram_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | dual_port_bram_ctl                                                         |
// | True dual-port RAM: byte enables, RDW modes, clear sweep, collision flag.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dual_port_bram_ctl
  import bram_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int Depth        = 1024,
  parameter int ReadLatency  = 1,
  parameter int WriteMode    = 0,
  parameter int ClearOnReset = 1,
  localparam int c_aw        = $clog2(Depth) + 1,
  localparam int c_bew       = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_en_i,
  input  logic                 a_we_i,
  input  logic [c_bew-1:0]     a_be_i,
  input  logic [c_aw-1:0]      a_addr_i,
  input  logic [DataWidth-1:0] a_data_i,
  output logic [DataWidth-1:0] a_q_o,
  output logic                 a_rvalid_o,
  output logic                 a_err_o,
  input  logic                 b_en_i,
  input  logic                 b_we_i,
  input  logic [c_bew-1:0]     b_be_i,
  input  logic [c_aw-1:0]      b_addr_i,
  input  logic [DataWidth-1:0] b_data_i,
  output logic [DataWidth-1:0] b_q_o,
  output logic                 b_rvalid_o,
  output logic                 b_err_o,
  output logic                 busy_o,
  output logic                 collision_o
);

  localparam int                 c_iw       = c_aw - 1;
  localparam logic [c_iw-1:0]    c_last_idx = c_iw'(Depth - 1);
  localparam logic [c_aw-1:0]    c_depth    = c_aw'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  clear_state_e         r_state;
  clear_state_e         w_state_nxt;
  logic [c_iw-1:0]      r_clr_addr;
  logic                 w_busy;
  logic                 w_clr_done;
  logic                 r_collision;

  logic                 w_a_acc, w_a_inr, w_a_wr, w_a_hold;
  logic                 w_b_acc, w_b_inr, w_b_wr, w_b_hold;
  logic [c_iw-1:0]      w_a_idx, w_b_idx;
  logic [DataWidth-1:0] w_a_old, w_b_old, w_a_rd, w_b_rd;

  function automatic logic [DataWidth-1:0] rd_word(
    input logic                 inr,
    input logic                 we,
    input logic [DataWidth-1:0] old_w,
    input logic [DataWidth-1:0] new_w,
    input logic [c_bew-1:0]     be
  );
    if (!inr) return '0;
    if (we && (WriteMode == int'(WRITE_FIRST)))
      return DataWidth'(be_merge(c_max_dw'(old_w), c_max_dw'(new_w), c_max_be'(be)));
    return old_w;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= (ClearOnReset != 0) ? ClearRun : ClearIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state == ClearRun);
    w_clr_done  = w_busy && (r_clr_addr == c_last_idx);
    if (w_clr_done) w_state_nxt = ClearIdle;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    r_clr_addr <= '0;
    else if (w_busy && !w_clr_done) r_clr_addr <= r_clr_addr + 1'b1;
  end

  assign w_a_acc  = a_en_i & ~w_busy & ~rst_i;
  assign w_b_acc  = b_en_i & ~w_busy & ~rst_i;
  assign w_a_inr  = (a_addr_i < c_depth);
  assign w_b_inr  = (b_addr_i < c_depth);
  assign w_a_idx  = a_addr_i[c_iw-1:0];
  assign w_b_idx  = b_addr_i[c_iw-1:0];
  assign w_a_wr   = w_a_acc & a_we_i & w_a_inr;
  assign w_b_wr   = w_b_acc & b_we_i & w_b_inr;
  assign w_a_old  = w_a_inr ? r_mem[w_a_idx] : '0;
  assign w_b_old  = w_b_inr ? r_mem[w_b_idx] : '0;
  assign w_a_rd   = rd_word(w_a_inr, a_we_i, w_a_old, a_data_i, a_be_i);
  assign w_b_rd   = rd_word(w_b_inr, b_we_i, w_b_old, b_data_i, b_be_i);
  assign w_a_hold = a_we_i & w_a_inr & (WriteMode == int'(NO_CHANGE));
  assign w_b_hold = b_we_i & w_b_inr & (WriteMode == int'(NO_CHANGE));

  // Port B lanes are written first so port A's overlapping lanes take precedence.
  always_ff @(posedge clk_i) begin
    if (w_busy) begin
      if (!rst_i) r_mem[r_clr_addr] <= '0;
    end else begin
      for (int i = 0; i < c_bew; i++) begin
        if (w_b_wr && b_be_i[i]) r_mem[w_b_idx][8*i +: 8] <= b_data_i[8*i +: 8];
        if (w_a_wr && a_be_i[i]) r_mem[w_a_idx][8*i +: 8] <= a_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_collision <= 1'b0;
    else       r_collision <= w_a_wr & w_b_wr & (w_a_idx == w_b_idx) & (|(a_be_i & b_be_i));
  end

  assign busy_o      = w_busy;
  assign collision_o = r_collision;

  bram_read_pipe #(.DataWidth(DataWidth), .ReadLatency(ReadLatency)) u_pipe_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_valid  (w_a_acc),
    .i_err    (~w_a_inr),
    .i_hold   (w_a_hold),
    .i_data   (w_a_rd),
    .o_q      (a_q_o),
    .o_rvalid (a_rvalid_o),
    .o_err    (a_err_o)
  );

  bram_read_pipe #(.DataWidth(DataWidth), .ReadLatency(ReadLatency)) u_pipe_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_valid  (w_b_acc),
    .i_err    (~w_b_inr),
    .i_hold   (w_b_hold),
    .i_data   (w_b_rd),
    .o_q      (b_q_o),
    .o_rvalid (b_rvalid_o),
    .o_err    (b_err_o)
  );

endmodule
`default_nettype wire

// File: doc/dual_port_bram_ctl.md
Name: dual_port_bram_ctl

Overview:
- True dual-port block RAM with byte-enable writes, a selectable same-port read-during-write mode and a 1- or 2-cycle read pipeline.
- Also provides an optional post-reset clear sweep, out-of-range address detection and cross-port write-collision reporting.
- Sits under the layer-weight and activation buffers of the inference datapath, where one port is fed by the loader and the other by the compute engine.

Parameters:
- DataWidth, 32, word width in bits; must be a multiple of 8.
- Depth, 1024, number of words; need not be a power of two.
- ReadLatency, 1, enable-to-data latency in cycles; legal values 1 or 2. 2 adds an output register.
- WriteMode, 0, same-port read-during-write: 0 read-first (old word), 1 write-first (merged new word), 2 no-change (q holds).
- ClearOnReset, 1, 1 = zero every word after reset release; 0 = no sweep.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- a_en_i  in  1  port A access enable
- a_we_i  in  1  port A write (qualified by a_en_i)
- a_be_i  in  DataWidth/8  port A byte enables
- a_addr_i  in  $clog2(Depth)+1  port A word address; extra MSB allows out-of-range detection
- a_data_i  in  DataWidth  port A write data
- a_q_o  out  DataWidth  port A read data
- a_rvalid_o  out  1  port A read data valid
- a_err_o  out  1  port A out-of-range access, aligned with a_rvalid_o
- b_* (same eight signals)  port B, identical semantics
- busy_o  out  1  clear sweep in progress; requests are ignored
- collision_o  out  1  cross-port same-address write detected

Behaviour:
- Reset (rst_i high, asynchronous):
  - a_q_o, b_q_o = 0; rvalid, err and collision_o = 0.
  - Pipeline registers are cleared.
  - Array contents are not reset.
  - busy_o = ClearOnReset.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR if ClearOnReset=1, otherwise IDLE.
  - In CLEAR, one word is written to 0 per cycle, address 0..Depth-1, through port A's write path.
  - After writing Depth-1, the FSM goes to IDLE and busy_o falls on the following edge. The sweep takes exactly Depth cycles after the first edge following reset release.
  - Reset asserted mid-sweep restarts the sweep from address 0.
  - While busy_o=1, both ports' en are ignored: no writes, rvalid stays 0.
- Access (per port, IDLE only):
  - en=1, we=0 is a read. rvalid pulses exactly ReadLatency cycles after the enable edge, with q valid in the same cycle.
  - q holds its last value when rvalid=0.
  - Back-to-back reads sustain one per cycle.
- Writes:
  - en=1, we=1 updates each byte lane i where be[i]=1 on that edge.
  - A write also produces a read with rvalid timing. Returned data follows WriteMode:
    - 0: pre-write word.
    - 1: merged post-write word.
    - 2: q unchanged, but rvalid still pulses.
- Out of range (addr >= Depth with en=1):
  - No array access.
  - The read result is 0 and err pulses together with rvalid.
  - In-range accesses never assert err.
- Cross-port behaviour:
  - Read on one port while the other writes the same address on the same edge returns the old word.
  - Both ports write the same in-range address on the same edge with overlapping be: port A's bytes win on the overlapping lanes, and port B's non-overlapping lanes still apply.
  - collision_o pulses high one cycle after such an edge. Non-overlapping be gives no collision.
- Arithmetic: the address comparison is unsigned, full width.

Decomposition:
- Shared package bram_pkg:
  - write_mode_e enum: READ_FIRST=0, WRITE_FIRST=1, NO_CHANGE=2.
  - ClearIdle/ClearRun state typedef.
  - Function be_merge(old, new, be) for byte-lane merging.
- Sub-module bram_read_pipe: per-port ReadLatency delay of {q, rvalid, err}, instantiated twice.

Test Plan:
- Clear sweep: Depth=16, ClearOnReset=1; release reset -> busy_o high exactly 16 cycles. Then read all 16 addresses -> q=0, rvalid one cycle after each en, err=0.
- Byte-enable merge, WriteMode=0:
  - Write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - The second write's q returns 0xAABBCCDD.
  - A subsequent read returns 0xAA22CC44.
- Write-first and latency: WriteMode=1, ReadLatency=2; write 0x12345678 to addr 3 -> a_q_o=0x12345678, rvalid 2 cycles after en.
- Collision:
  - Same edge: A writes 0x000000FF with be=0001 to addr 7, B writes 0x0000EE11 with be=0011 to addr 7.
  - collision_o high next cycle.
  - A read of addr 7 returns 0x0000EEFF.
- Out of range: Depth=1000; read addr 1000 and 2047 -> q=0, err=1 with rvalid. Write 0xDEADBEEF to addr 1000 -> array unchanged, err=1.
- Mid-sweep reset: Depth=16; assert rst_i at sweep cycle 9 for 2 cycles -> outputs zero immediately, busy_o stays 1, and a fresh 16-cycle sweep follows.
